// File: rtl/muldiv_pkg.sv
`default_nettype none
// ==========================================================================
// muldiv_pkg - op/state encodings and width-generic constant helpers
// Revision: 1.0
// ==========================================================================
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int MAX_XLEN = 128;

  function automatic logic [MAX_XLEN-1:0] min_int(input int xlen);
    return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
  endfunction

  function automatic logic [MAX_XLEN-1:0] all_ones(input int xlen);
    return ({{(MAX_XLEN-1){1'b0}}, 1'b1} << xlen) - {{(MAX_XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ==========================================================================
// muldiv_negate - combinational conditional two's-complement of width W
// Revision: 1.0
// ==========================================================================
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ==========================================================================
// muldiv_unit - multi-cycle MUL/MULH*/DIV*/REM* unit; MULDIV_RESULT_CACHE_EN adds a divide result cache
// Revision: 1.0
// ==========================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o,
  output logic             ready_o
);

  localparam logic [XLEN-1:0]  C_MIN_INT = XLEN'(min_int(XLEN));
  localparam logic [XLEN-1:0]  C_ONES    = XLEN'(all_ones(XLEN));
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(XLEN - 1);

  state_e              state_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     m_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [2*XLEN-1:0]   prod_d;
  logic [TAG_W-1:0]    tag_q;

  logic                w_sa, w_sb, w_neg_start, w_div0, w_ovf, w_hit, w_accept;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_res;
  logic [XLEN:0]       w_add, w_shl, w_diff;
  logic [2*XLEN-1:0]   w_fix_in, w_fix, w_hit_prod;

  assign w_sa        = op_a_signed(op_i) & op_a_i[XLEN-1];
  assign w_sb        = op_b_signed(op_i) & op_b_i[XLEN-1];
  assign w_neg_start = (op_i == OP_REM) ? w_sa : (w_sa ^ w_sb);
  assign w_div0      = op_i[2] && (op_b_i == '0);
  assign w_ovf       = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (op_a_i == C_MIN_INT) && (op_b_i == C_ONES);
  assign w_accept    = (state_q == ST_IDLE) && start_i && !flush_i;

  muldiv_negate #(.W(XLEN)) u_mag_a (.neg_i(w_sa), .val_i(op_a_i), .val_o(w_mag_a));
  muldiv_negate #(.W(XLEN)) u_mag_b (.neg_i(w_sb), .val_i(op_b_i), .val_o(w_mag_b));

  // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
  assign w_add  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
  assign w_shl  = prod_q[2*XLEN-1:XLEN-1];
  assign w_diff = w_shl - {1'b0, m_q};

  always_comb begin
    if (!op_q[2]) begin
      prod_d = {w_add, prod_q[XLEN-1:1]};
    end else if (w_diff[XLEN]) begin
      prod_d = {w_shl[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end else begin
      prod_d = {w_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end
  end

  assign w_fix_in = !op_q[2] ? prod_q :
                    {{XLEN{1'b0}}, (op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0])};

  muldiv_negate #(.W(2*XLEN)) u_fix (.neg_i(neg_q), .val_i(w_fix_in), .val_o(w_fix));

  assign w_res    = ((op_q == OP_MUL) || op_q[2]) ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
  assign ready_o  = (state_q == ST_FIX) && !flush_i;
  assign result_o = ready_o ? w_res : '0;
  assign tag_o    = tag_q;
  assign busy_o   = busy_q;

`ifdef MULDIV_RESULT_CACHE_EN
  logic              cv_q, cs_q, ks_q;
  logic [XLEN-1:0]   ca_q, cb_q, ka_q, kb_q;
  logic [2*XLEN-1:0] cp_q;

  // Cached entry keeps raw magnitudes; sign correction is re-derived on a hit
  assign w_hit      = cv_q && op_i[2] && (op_a_i == ca_q) && (op_b_i == cb_q) && (cs_q == !op_i[0]);
  assign w_hit_prod = cp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q <= 1'b0;
      cs_q <= 1'b0;
      ks_q <= 1'b0;
      ca_q <= '0;
      cb_q <= '0;
      ka_q <= '0;
      kb_q <= '0;
      cp_q <= '0;
    end else begin
      if (w_accept) begin
        ka_q <= op_a_i;
        kb_q <= op_b_i;
        ks_q <= !op_i[0];
      end
      if ((state_q == ST_FIX) && busy_q && op_q[2] && !flush_i) begin
        cv_q <= 1'b1;
        ca_q <= ka_q;
        cb_q <= kb_q;
        cs_q <= ks_q;
        cp_q <= prod_q;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_prod = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            op_q   <= op_i;
            tag_q  <= tag_i;
            cnt_q  <= C_LAST;
            neg_q  <= w_neg_start;
            m_q    <= op_i[2] ? w_mag_b : w_mag_a;
            prod_q <= {{XLEN{1'b0}}, (op_i[2] ? w_mag_a : w_mag_b)};
            if (w_div0) begin
              prod_q  <= {op_a_i, C_ONES};
              neg_q   <= 1'b0;
              state_q <= ST_FIX;
            end else if (w_ovf) begin
              prod_q  <= {{XLEN{1'b0}}, C_MIN_INT};
              neg_q   <= 1'b0;
              state_q <= ST_FIX;
            end else if (w_hit) begin
              prod_q  <= w_hit_prod;
              state_q <= ST_FIX;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle M-extension unit and next generation of the core's divide-only unit. Adds the MUL, MULH, MULHSU and MULHU operations to DIV, DIVU, REM and REMU. Adds a configurable XLEN, a pass-through destination tag, and a flush input that aborts work on jump or trap. Sits beside ex: ex asserts start_i, holds the pipeline while busy_o is high, and writes back result_o to tag_o when ready_o pulses.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
TAG_W, 5, width of the pass-through tag (destination register address)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request; sampled only in IDLE
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  in  XLEN  rs1 value (multiplicand / dividend)
op_b_i  in  XLEN  rs2 value (multiplier / divisor)
tag_i  in  TAG_W  destination tag, captured with the operands
flush_i  in  1  abort the current operation
result_o  out  XLEN  result; valid only while ready_o=1
tag_o  out  TAG_W  captured tag; valid while ready_o=1
busy_o  out  1  high from the cycle after accept until the ready cycle (inclusive of CALC and FIX)
ready_o  out  1  single-cycle completion pulse

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. Reset forces state to IDLE and clears every output and internal register to 0 (result_o=0, tag_o=0, busy_o=0, ready_o=0).
- FSM states:
  - IDLE: on start_i=1 and flush_i=0, latch op, |operands| and tag, then go to CALC, or to FIX for the fast paths below.
  - CALC: one radix-2 step per cycle for XLEN cycles. Multiply uses shift-add on a 2*XLEN product. Divide uses restoring division. Then go to FIX.
  - FIX: apply sign correction and select the low/high half, quotient or remainder. Drive result_o, tag_o and ready_o=1 for exactly this cycle, then go to IDLE.
- Latency: start at cycle 0 gives ready at cycle XLEN+1. Fast paths give ready at cycle 1.
- Fast path, divide by zero (op_b=0): DIV/DIVU return all ones; REM/REMU return op_a.
- Fast path, signed overflow (DIV/REM with op_a = 1 followed by XLEN-1 zeros, op_b all ones): DIV returns op_a; REM returns 0.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV/REM: operate on magnitudes. Quotient negated when the operand signs differ. Remainder takes the sign of the dividend.
- Sign correction uses two's-complement negation at the width of the value corrected (XLEN or 2*XLEN); overflow wraps.
- start_i in CALC or FIX is ignored; no queueing. The caller must hold until ready_o.
- flush_i=1 in any state: go to IDLE next cycle, with busy_o=0 and no ready_o for the aborted operation.
- flush_i in the same cycle as start_i: flush wins and the request is dropped.
- flush_i in FIX: ready_o is suppressed that cycle.
- Operands and tag are registered at accept; later changes on op_a_i, op_b_i and tag_i have no effect.
- A new start may be accepted in the cycle after ready_o (back-to-back throughput of XLEN+2 cycles).

Optional Feature:
MULDIV_RESULT_CACHE_EN
- Defined: on every completed divide-class operation, store the quotient, the remainder, op_a, op_b and a signed flag, and set a valid bit.
- A later DIV/REM (or DIVU/REMU) with identical operands and signedness takes the fast path: ready_o at cycle 1, busy_o never asserted.
- Reset clears the valid bit. flush_i does not clear it; an aborted operation never writes the cache.
- Undefined: no cache logic; every divide takes the full latency.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MUL through OP_REMU
  - FSM state encoding: ST_IDLE, ST_CALC, ST_FIX
  - helper constants for the MIN_INT and all-ones patterns, built from XLEN
- One natural sub-module: muldiv_negate, a combinational conditional two's-complement of width W. It is instantiated for operand magnitude (XLEN) and for result correction (2*XLEN).

Test Plan:
- XLEN=32, MULHSU a=0xFFFFFFFF (-1), b=0x00000002 -> ready at cycle 33, result 0xFFFFFFFF; MUL with the same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2; tag_o equals tag_i.
- DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 1; REM a=0x80000000, b=0xFFFFFFFF -> 0 at cycle 1; busy_o stays 0 in both.
- Start a DIV, assert flush_i at cycle 10 -> busy_o=0 at cycle 11, no ready_o. An immediate restart with new operands returns the correct result; start+flush in the same cycle is ignored.
- rst_n asserted mid-CALC -> busy_o, ready_o and result_o read 0 immediately (asynchronously). After release the unit accepts a new start; start_i pulsed while busy is ignored.
- With MULDIV_RESULT_CACHE_EN: DIV 1000/3 -> 333 at cycle 33, then REM 1000/3 -> 1 at cycle 1. After a reset the same REM takes 33 cycles.
